// File: rtl/pulse_stretcher_pkg.sv
// Shared types and helpers for the pulse stretcher: lane state, counter sizing, default hold.
// Optional retrigger behaviour is selected with PULSE_STRETCH_RETRIG_EN (see pulse_stretcher_lane).
package pulse_stretcher_pkg;

    localparam int DEFAULT_HOLD_CYCLES = 4;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } lane_state_e;

    // Counter holds HOLD_CYCLES-1 down to 0; an illegal hold length still yields a legal width
    // so the top-level elaboration check can report it instead of a width error.
    function automatic int cnt_width(input int hold_cycles);
        return (hold_cycles < 1) ? 1 : $clog2(hold_cycles + 1);
    endfunction

endpackage : pulse_stretcher_pkg

// File: rtl/pulse_stretcher_if.sv
// Per-lane trigger/ack/clear inputs and level/done/overrun outputs of the pulse stretcher.
// The slave modport is the stretcher side; master is the event source / consumer side.
interface pulse_stretcher_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] pulse_in;
    logic [WIDTH-1:0] ack;
    logic [WIDTH-1:0] ovr_clr;
    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] done;
    logic [WIDTH-1:0] ovr;

    modport master (
        output pulse_in, ack, ovr_clr,
        input  level, done, ovr
    );

    modport slave (
        input  pulse_in, ack, ovr_clr,
        output level, done, ovr
    );
endinterface : pulse_stretcher_if

// File: rtl/pulse_stretcher_lane.sv
// One stretcher lane: IDLE/HOLD FSM, hold down-counter, timeout done pulse, sticky overrun.
// PULSE_STRETCH_RETRIG_EN defined: a pulse during HOLD reloads the hold; otherwise it is dropped and flagged.
module pulse_stretcher_lane
    import pulse_stretcher_pkg::*;
#(
    parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES,
    parameter int CNT_W       = cnt_width(HOLD_CYCLES)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pulse_in,
    input  logic ack,
    input  logic ovr_clr,
    output logic level,
    output logic done,
    output logic ovr
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

    lane_state_e      state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             done_n;
    logic             ovr_set;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_n = state;
        cnt_n   = cnt;
        done_n  = 1'b0;
        ovr_set = 1'b0;
        unique case (state)
            IDLE: begin
                if (pulse_in) begin
                    state_n = HOLD;
                    cnt_n   = CNT_LOAD;
                end
            end
            HOLD: begin
`ifdef PULSE_STRETCH_RETRIG_EN
                if (pulse_in) begin
                    cnt_n = CNT_LOAD;
                end else if (ack) begin
                    state_n = IDLE;
                end else if (cnt == '0) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
`else
                // The extra pulse is only flagged; the hold proceeds as if it never came.
                ovr_set = pulse_in;
                if (ack) begin
                    state_n = IDLE;
                end else if (cnt == '0) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
`endif
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with non-blocking assignments only.
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            done  <= done_n;
        end
    end

    assign level = (state == HOLD);

`ifdef PULSE_STRETCH_RETRIG_EN
    // Retriggering never overruns, so the flag and its clear have nothing to do.
    logic unused_ovr;
    assign unused_ovr = ovr_set ^ ovr_clr;
    assign ovr        = 1'b0;
`else
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovr <= 1'b0;
        end else if (ovr_set) begin
            ovr <= 1'b1;
        end else if (ovr_clr) begin
            ovr <= 1'b0;
        end
    end
`endif

endmodule : pulse_stretcher_lane

// File: rtl/pulse_stretcher.sv
// Top of the pulse stretcher: WIDTH independent lanes turning single-cycle events into held levels.
// Build option PULSE_STRETCH_RETRIG_EN selects retrigger mode; default is one-shot with overrun flag.
module pulse_stretcher
    import pulse_stretcher_pkg::*;
#(
    parameter int WIDTH       = 1,
    parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES
) (
    input  logic              clk,
    input  logic              rst_n,
    pulse_stretcher_if.slave  bus
);

    localparam int CNT_W = cnt_width(HOLD_CYCLES);

    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("pulse_stretcher: HOLD_CYCLES must be at least 1");
    end

    logic [WIDTH-1:0] level_w;
    logic [WIDTH-1:0] done_w;
    logic [WIDTH-1:0] ovr_w;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        pulse_stretcher_lane #(
            .HOLD_CYCLES (HOLD_CYCLES),
            .CNT_W       (CNT_W)
        ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .pulse_in (bus.pulse_in[i]),
            .ack      (bus.ack[i]),
            .ovr_clr  (bus.ovr_clr[i]),
            .level    (level_w[i]),
            .done     (done_w[i]),
            .ovr      (ovr_w[i])
        );
    end

    assign bus.level = level_w;
    assign bus.done  = done_w;
    assign bus.ovr   = ovr_w;

endmodule : pulse_stretcher

// File: tb/tb_pulse_stretcher.sv
// Bench for pulse_stretcher: a 2-lane/hold-4 and a 1-lane/hold-1 instance, directed cases plus
// random traffic, compared every cycle against a deadline-based model of the lane rules.
module tb_pulse_stretcher;

    localparam int A_W = 2;
    localparam int A_H = 4;
    localparam int B_W = 1;
    localparam int B_H = 1;
    localparam int N   = A_W + B_W;

`ifdef PULSE_STRETCH_RETRIG_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pulse_stretcher_if #(.WIDTH(A_W)) bus_a ();
    pulse_stretcher_if #(.WIDTH(B_W)) bus_b ();

    pulse_stretcher #(.WIDTH(A_W), .HOLD_CYCLES(A_H)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    pulse_stretcher #(.WIDTH(B_W), .HOLD_CYCLES(B_H)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, model_cyc, act, exp);
        end
    endtask

    // Model: each lane is described by the last cycle its level must be high (hold_until).
    // Cycle c is the interval ending at the c-th rising edge; inputs of cycle c shape cycle c+1.
    int model_cyc = 0;
    int hold_until [N] = '{-1, -1, -1};
    int hold_len   [N] = '{A_H, A_H, B_H};
    bit exp_level  [N];
    bit exp_done   [N];
    bit exp_ovr    [N];

    always @(posedge clk) begin : model
        logic [N-1:0] p, a, cl;
        bit active, rel, oset;
        p  = {bus_b.pulse_in, bus_a.pulse_in};
        a  = {bus_b.ack, bus_a.ack};
        cl = {bus_b.ovr_clr, bus_a.ovr_clr};
        for (int l = 0; l < N; l++) begin
            active = (model_cyc <= hold_until[l]);
            rel    = 1'b0;
            oset   = 1'b0;
            if (!rst_n) begin
                hold_until[l] = -1;
                exp_done[l]   = 1'b0;
                exp_ovr[l]    = 1'b0;
            end else begin
                if (!active) begin
                    if (p[l]) hold_until[l] = model_cyc + hold_len[l];
                end else if (RETRIG) begin
                    if (p[l]) hold_until[l] = model_cyc + hold_len[l];
                    else if (a[l]) begin
                        hold_until[l] = model_cyc;
                        rel = 1'b1;
                    end
                end else begin
                    oset = p[l];
                    if (a[l]) begin
                        hold_until[l] = model_cyc;
                        rel = 1'b1;
                    end
                end
                exp_done[l] = active && !rel && (hold_until[l] <= model_cyc);
                exp_ovr[l]  = oset || (exp_ovr[l] && !cl[l]);
            end
            exp_level[l] = (model_cyc + 1 <= hold_until[l]);
        end
        model_cyc++;
    end

    logic [N-1:0] act_level, act_done, act_ovr;
    assign act_level = {bus_b.level, bus_a.level};
    assign act_done  = {bus_b.done, bus_a.done};
    assign act_ovr   = {bus_b.ovr, bus_a.ovr};

    always @(negedge clk) begin : compare
        if (model_cyc >= 1) begin
            for (int l = 0; l < N; l++) begin
                check($sformatf("model level[%0d]", l), 8'(act_level[l]), 8'(exp_level[l]));
                check($sformatf("model done[%0d]", l), 8'(act_done[l]), 8'(exp_done[l]));
                check($sformatf("model ovr[%0d]", l), 8'(act_ovr[l]), 8'(exp_ovr[l]));
            end
        end
    end

    // Lands on the falling edge inside cycle t; inputs set there belong to cycle t.
    task automatic goto_cyc(input int t);
        while (model_cyc < t) @(negedge clk);
    endtask

    function automatic logic rbit(input int pct);
        return ($urandom_range(99) < pct);
    endfunction

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", model_cyc);
        $fatal(1, "time limit");
    end

    initial begin : stim
        bus_a.pulse_in = '0; bus_a.ack = '0; bus_a.ovr_clr = '0;
        bus_b.pulse_in = '0; bus_b.ack = '0; bus_b.ovr_clr = '0;

        goto_cyc(2);
        check("reset level a", 8'(bus_a.level), 8'h00);
        check("reset done a", 8'(bus_a.done), 8'h00);
        check("reset ovr a", 8'(bus_a.ovr), 8'h00);
        check("reset level b", 8'(bus_b.level), 8'h00);
        rst_n = 1'b1;

        // Basic hold: level 11..14, done in 15.
        goto_cyc(10); bus_a.pulse_in = 2'b01;
        goto_cyc(11); bus_a.pulse_in = 2'b00;
        check("basic level c11", 8'(bus_a.level), 8'h01);
        goto_cyc(14); check("basic level c14", 8'(bus_a.level), 8'h01);
        goto_cyc(15);
        check("basic level c15", 8'(bus_a.level), 8'h00);
        check("basic done c15", 8'(bus_a.done), 8'h01);
        check("basic ovr c15", 8'(bus_a.ovr), 8'h00);
        goto_cyc(16); check("basic done c16", 8'(bus_a.done), 8'h00);

        // Early ack: level 31..32 only, no done.
        goto_cyc(30); bus_a.pulse_in = 2'b01;
        goto_cyc(31); bus_a.pulse_in = 2'b00;
        goto_cyc(32); check("ack level c32", 8'(bus_a.level), 8'h01); bus_a.ack = 2'b01;
        goto_cyc(33); bus_a.ack = 2'b00;
        check("ack level c33", 8'(bus_a.level), 8'h00);
        check("ack done c33", 8'(bus_a.done), 8'h00);
        goto_cyc(34); check("ack done c34", 8'(bus_a.done), 8'h00);

        // Second pulse during hold at 53.
        goto_cyc(50); bus_a.pulse_in = 2'b01;
        goto_cyc(51); bus_a.pulse_in = 2'b00;
        goto_cyc(53); bus_a.pulse_in = 2'b01;
        check("second ovr c53", 8'(bus_a.ovr), 8'h00);
        goto_cyc(54); bus_a.pulse_in = 2'b00;
        check("second level c54", 8'(bus_a.level), 8'h01);
        check("second ovr c54", 8'(bus_a.ovr), RETRIG ? 8'h00 : 8'h01);
        goto_cyc(55);
        check("second level c55", 8'(bus_a.level), RETRIG ? 8'h01 : 8'h00);
        check("second done c55", 8'(bus_a.done), RETRIG ? 8'h00 : 8'h01);
        goto_cyc(57); check("second level c57", 8'(bus_a.level), RETRIG ? 8'h01 : 8'h00);
        goto_cyc(58);
        check("second level c58", 8'(bus_a.level), 8'h00);
        check("second done c58", 8'(bus_a.done), RETRIG ? 8'h01 : 8'h00);
        goto_cyc(60); check("ovr held c60", 8'(bus_a.ovr), RETRIG ? 8'h00 : 8'h01);
        bus_a.ovr_clr = 2'b01;
        goto_cyc(61); bus_a.ovr_clr = 2'b00;
        check("ovr cleared c61", 8'(bus_a.ovr), 8'h00);

        // Reset mid-hold on lane 1, then a fresh hold 76..79.
        goto_cyc(70); bus_a.pulse_in = 2'b10;
        goto_cyc(71); bus_a.pulse_in = 2'b00;
        goto_cyc(72); check("rst level c72", 8'(bus_a.level), 8'h02); rst_n = 1'b0;
        goto_cyc(73); rst_n = 1'b1;
        check("rst level c73", 8'(bus_a.level), 8'h00);
        check("rst done c73", 8'(bus_a.done), 8'h00);
        goto_cyc(75); bus_a.pulse_in = 2'b10;
        check("rst done c75", 8'(bus_a.done), 8'h00);
        goto_cyc(76); bus_a.pulse_in = 2'b00;
        check("rehold level c76", 8'(bus_a.level), 8'h02);
        goto_cyc(79); check("rehold level c79", 8'(bus_a.level), 8'h02);
        goto_cyc(80);
        check("rehold level c80", 8'(bus_a.level), 8'h00);
        check("rehold done c80", 8'(bus_a.done), 8'h02);

        // One-cycle hold with back-to-back pulses at 90 and 91.
        goto_cyc(90); bus_b.pulse_in = 1'b1;
        goto_cyc(91); check("h1 level c91", 8'(bus_b.level), 8'h01);
        goto_cyc(92); bus_b.pulse_in = 1'b0;
        check("h1 level c92", 8'(bus_b.level), RETRIG ? 8'h01 : 8'h00);
        check("h1 done c92", 8'(bus_b.done), RETRIG ? 8'h00 : 8'h01);
        check("h1 ovr c92", 8'(bus_b.ovr), RETRIG ? 8'h00 : 8'h01);
        bus_b.ovr_clr = 1'b1;
        goto_cyc(93); bus_b.ovr_clr = 1'b0;
        check("h1 level c93", 8'(bus_b.level), 8'h00);
        check("h1 done c93", 8'(bus_b.done), RETRIG ? 8'h01 : 8'h00);
        check("h1 ovr c93", 8'(bus_b.ovr), 8'h00);

        // Overrun set and clear in the same cycle: set wins.
        goto_cyc(100); bus_b.pulse_in = 1'b1;
        goto_cyc(101); bus_b.ovr_clr = 1'b1;
        goto_cyc(102); bus_b.pulse_in = 1'b0; bus_b.ovr_clr = 1'b0;
        check("set beats clear c102", 8'(bus_b.ovr), RETRIG ? 8'h00 : 8'h01);

        // Random traffic on both instances, occasional reset.
        goto_cyc(110);
        for (int i = 0; i < 3000; i++) begin
            bus_a.pulse_in = {rbit(25), rbit(25)};
            bus_a.ack      = {rbit(10), rbit(10)};
            bus_a.ovr_clr  = {rbit(10), rbit(10)};
            bus_b.pulse_in = rbit(35);
            bus_b.ack      = rbit(10);
            bus_b.ovr_clr  = rbit(10);
            rst_n          = !rbit(1);
            @(negedge clk);
        end
        bus_a.pulse_in = '0; bus_a.ack = '0; bus_a.ovr_clr = '0;
        bus_b.pulse_in = '0; bus_b.ack = '0; bus_b.ovr_clr = '0;
        rst_n = 1'b1;
        repeat (8) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_pulse_stretcher

// File: doc/pulse_stretcher.md
Name: pulse_stretcher

Overview:
- Converts single-cycle event pulses, such as those produced by the design's edge pulsers, back into held levels. Each asserted lane holds its level for a fixed number of cycles, or until acknowledged.
- Sits between sequencer event sources and slow or level-sensitive consumers: DFX decoupler enables, status LEDs, cross-domain handshakes.
- Each lane is independent, with a timeout-done pulse and a sticky overrun flag.

Parameters:
- WIDTH, 1: number of independent lanes.
- HOLD_CYCLES, 4: level duration in cycles per trigger. Legal range is 1 or more; values below 1 are a compile-time error.
- CNT_W, $clog2(HOLD_CYCLES+1): hold counter width. Derived; do not override.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  reset, synchronous and active-low.
- pulse_in  in  WIDTH  per-lane trigger pulses, sampled on clk rising edge.
- ack  in  WIDTH  per-lane early release of the held level.
- ovr_clr  in  WIDTH  per-lane clear of the sticky overrun flag.
- level  out  WIDTH  per-lane stretched level (registered).
- done  out  WIDTH  one-cycle pulse when a hold ends by timeout.
- ovr  out  WIDTH  sticky per-lane overrun flag.

Behaviour:
- Reset, synchronous on rst_n=0 at a clk edge: state IDLE, cnt=0, level=0, done=0, ovr=0 on all lanes. Reset overrides all inputs, including mid-hold; level drops the cycle after reset is sampled.
- Per-lane FSM has two states: IDLE and HOLD.
- IDLE with pulse_in=1:
  - Go to HOLD, load cnt=HOLD_CYCLES-1.
  - level=1 from the next cycle.
  - ack is ignored in IDLE.
- HOLD timing: pulse_in high in cycle t gives level high in cycles t+1 through t+HOLD_CYCLES inclusive. Latency is 1 cycle.
- HOLD with no pulse_in and no ack:
  - If cnt==0, go to IDLE, level=0 next cycle, done=1 for exactly that one cycle.
  - Otherwise decrement cnt.
- HOLD with ack=1 and pulse_in=0: go to IDLE, level=0 next cycle, done stays 0.
- HOLD with pulse_in=1 has mode-dependent behaviour; see Optional Feature.
- ovr: set per lane as described under Optional Feature.
  - ovr_clr=1 clears it the next cycle.
  - Simultaneous set and clear: set wins.
- HOLD_CYCLES=1: each trigger gives a 1-cycle level; done coincides with level falling.
- Lanes share no state. Simultaneous events on different lanes are fully independent.

Optional Feature:
- Macro: PULSE_STRETCH_RETRIG_EN.
- Defined (retrigger mode):
  - pulse_in in HOLD reloads cnt=HOLD_CYCLES-1, regardless of ack or cnt. level stays continuous, with no gap, and done is not asserted.
  - ovr is never set and is tied to 0.
- Undefined (one-shot mode):
  - pulse_in in HOLD is dropped and ovr is set. The hold continues, or ends, exactly as if no pulse had arrived.
  - ack plus pulse_in in HOLD: go to IDLE, ovr is set, and the pulse is not re-armed.

Decomposition:
- Package pulse_stretcher_pkg holds:
  - the lane state enum (IDLE, HOLD);
  - a function computing the counter width;
  - a localparam for the default HOLD_CYCLES.
- Sub-module pulse_stretcher_lane: one FSM, counter, and ovr bit per instance. The top generates WIDTH instances and concatenates their outputs.

Test Plan:
- Reset and basic hold (WIDTH=2, HOLD_CYCLES=4): hold rst_n=0 for 2 cycles, then release. pulse_in=2'b01 at cycle 10 -> level[0]=1 in cycles 11-14, done[0]=1 in cycle 15, level[1]=0 throughout, ovr=0.
- Early ack: pulse_in[0] at cycle 10, ack[0] at cycle 12 -> level[0]=1 in cycles 11-12 only, done[0] never asserts.
- Retrigger (macro defined): pulse_in[0] at cycles 10 and 13 -> level[0]=1 continuously in cycles 11-17, single done[0] in cycle 18, ovr=0.
- One-shot overrun (macro undefined): same stimulus -> level[0]=1 in cycles 11-14, done[0] in cycle 15, ovr[0]=1 from cycle 14 until ovr_clr[0] is pulsed at cycle 20, then ovr[0]=0 from cycle 21.
- Reset mid-hold: pulse_in[1] at cycle 10, rst_n=0 at cycle 12 -> level[1]=0 from cycle 13, no done pulse. A new pulse at cycle 15 (rst_n=1) gives level in cycles 16-19.
- HOLD_CYCLES=1 edge case: back-to-back pulses at cycles 5 and 6, retrigger mode -> level=1 in cycles 6-7, done only in cycle 8.
